// File: rtl/add_sub_serial_if.sv
// Handshake and data bundle for the digit-serial adder/subtractor lane.
interface add_sub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// so the carry chain is only DIGIT bits deep. Valid/ready on both sides.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  add_sub_serial_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             sub_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [CW-1:0]    cnt;

  logic [31:0]      base;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;

  always_comb begin
    base    = 32'(cnt) * 32'(DIGIT);
    dsum    = {1'b0, a_q[base +: DIGIT]} + {1'b0, b_q[base +: DIGIT]} + {{DIGIT{1'b0}}, carry};
    // A sum bit is a^b^cin, so the carry into the top bit is recovered from it.
    msb_cin = dsum[DIGIT-1] ^ a_q[base + 32'(DIGIT - 1)] ^ b_q[base + 32'(DIGIT - 1)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            sub_q <= bus.sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[base +: DIGIT] <= dsum[DIGIT-1:0];
          carry                <= dsum[DIGIT];
          if (cnt == CW'(N - 1)) begin
            cout_q      <= dsum[DIGIT] ^ sub_q;
            ovf_q       <= msb_cin ^ dsum[DIGIT];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
